// File: rtl/aes_result_scanner.sv
// Scans a 128-bit AES result block byte by byte (MSB first), converting each byte to
// 3-digit BCD with a sequential double-dabble engine and holding it for DWELL cycles.
module aes_result_scanner #(
   parameter int DWELL = 25000000,
   parameter bit LOOP  = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_block,
   output logic [11:0]  bcd_out,
   output logic         digit_valid,
   output logic [3:0]   byte_index,
   output logic         busy,
   output logic         done
);

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW-1:0] DWELL_M1 = DW'(DWELL - 1);

   typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_SHOW, S_DONE} state_t;

   state_t          state_q;
   logic [127:0]    block_q;
   logic [19:0]     work_q;
   logic [19:0]     work_d;
   logic [2:0]      iter_q;
   logic [DW-1:0]   dwell_q;
   logic [3:0]      idx_q;
   logic [11:0]     bcd_q;
   logic            dv_q;
   logic            done_q;

   // work_q = {hundreds, tens, units, binary}; one add-3-then-shift per cycle
   function automatic logic [19:0] dd_step(input logic [19:0] w);
      logic [19:0] t;
      t = w;
      for (int i = 0; i < 3; i++) begin
         if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
      end
      return t << 1;
   endfunction

   always_comb work_d = dd_step(work_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         block_q <= '0;
         work_q  <= '0;
         iter_q  <= '0;
         dwell_q <= '0;
         idx_q   <= '0;
         bcd_q   <= '0;
         dv_q    <= 1'b0;
         done_q  <= 1'b0;
      end else if (clear) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         bcd_q   <= '0;
         dv_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  block_q <= in_block;
                  work_q  <= {12'd0, in_block[127:120]};
                  iter_q  <= '0;
                  idx_q   <= '0;
                  dv_q    <= 1'b0;
                  state_q <= S_CONVERT;
               end
            end
            S_CONVERT: begin
               work_q <= work_d;
               iter_q <= iter_q + 3'd1;
               if (iter_q == 3'd7) begin
                  bcd_q   <= work_d[19:8];
                  dv_q    <= 1'b1;
                  dwell_q <= DWELL_M1;
                  state_q <= S_SHOW;
               end
            end
            S_SHOW: begin
               if (dwell_q == '0) begin
                  if (idx_q == 4'd15 && !LOOP) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     // block is rotated so the current byte always sits at the top;
                     // after 16 rotations byte 0 is back in place for a loop restart
                     idx_q   <= idx_q + 4'd1;
                     block_q <= {block_q[119:0], block_q[127:120]};
                     work_q  <= {12'd0, block_q[119:112]};
                     iter_q  <= '0;
                     state_q <= S_CONVERT;
                  end
               end else begin
                  dwell_q <= dwell_q - 1'b1;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign bcd_out     = bcd_q;
   assign digit_valid = dv_q;
   assign byte_index  = idx_q;
   assign done        = done_q;

endmodule

// File: doc/aes_result_scanner.md
Name: aes_result_scanner

Overview:
- Downstream consumer of the AES top-level encrypt/decrypt result.
- Accepts one 128-bit state block through a valid/ready handshake, then walks its 16 bytes MSB-first.
- Converts each byte to 3-digit BCD with a sequential shift-add-3 (double dabble) engine and holds each value for a programmable dwell time.
- Feeds the existing 7-segment display decoders, replacing the single fixed-byte display path.

Parameters:
- DWELL, 25000000: clock cycles each converted byte is held in the SHOW state. Must be ≥1; 0 is illegal.
- LOOP, 0: 0 = scan the 16 bytes once, then finish; 1 = restart at byte 0 after byte 15, until clear or reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort; highest priority below reset.
- in_valid  input  1  in_block is valid.
- in_ready  output  1  block can be accepted this cycle.
- in_block  input  128  AES state; byte 0 = in_block[127:120], byte 15 = in_block[7:0].
- bcd_out  output  12  [11:8] hundreds, [7:4] tens, [3:0] units of the current byte.
- digit_valid  output  1  bcd_out holds a completed conversion.
- byte_index  output  4  index of the byte being converted or shown.
- busy  output  1  scan in progress (any state except IDLE).
- done  output  1  one-cycle pulse after byte 15's dwell ends (LOOP=0 only).

Behaviour:
- Reset (reset=0, async): state=IDLE, in_ready=1, bcd_out=0, digit_valid=0, byte_index=0, busy=0, done=0. Any captured block is discarded.
- FSM states: IDLE, CONVERT, SHOW, DONE.
- IDLE:
  - in_ready=1.
  - The accept edge (edge 0) is the edge where in_valid&&in_ready. On that edge: latch in_block, byte_index←0, digit_valid←0, load the converter with byte 0, go to CONVERT.
  - in_valid in any other state is ignored; in_ready=0 outside IDLE.
- CONVERT:
  - Exactly 8 cycles; one shift-add-3 iteration per cycle. Before each shift, add 3 to any BCD nibble ≥5. Use an internal 20-bit working register.
  - On the 8th edge: bcd_out←result, digit_valid←1, dwell counter←DWELL-1, go to SHOW.
  - bcd_out keeps the previous byte's value during conversion.
- SHOW:
  - Counter decrements each cycle. When it is 0, the next edge leaves SHOW; SHOW therefore lasts exactly DWELL cycles.
  - If byte_index<15: byte_index←byte_index+1, load the next byte, go to CONVERT.
  - If byte_index==15 and LOOP=1: byte_index←0 (wrap), go to CONVERT.
  - If byte_index==15 and LOOP=0: go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - bcd_out and digit_valid keep the last byte (display holds) until the next accept, clear or reset.
- Timing (LOOP=0, accept at edge 0):
  - byte_index=k after edge 12k when DWELL=4; in general after edge k*(8+DWELL).
  - bcd_out for byte k valid after edge k*(8+DWELL)+8.
  - DONE entered at edge 16*(8+DWELL); in_ready high again after the following edge.
- clear=1 on an edge, any state: go to IDLE, bcd_out←0, digit_valid←0, byte_index←0, done←0. clear in IDLE with in_valid=1: clear wins, nothing accepted.
- busy = (state≠IDLE). Asserted the cycle after accept; deasserted the cycle after DONE.
- Widths: results never exceed 12'h255; the hundreds nibble is 0..2.
- Reset mid-scan: immediate return to reset values; no done pulse.

Test Plan:
- DWELL=4, LOOP=0; in_block=128'h69c4e0d86a7b0430d8cdb78070b4c55a accepted at edge 0 → bcd_out=12'h105 and digit_valid=1 after edge 8; 12'h196 after edge 20; 12'h090 (byte 15 = 0x5a) after edge 188; done high for exactly the cycle after edge 192; in_ready=1 after edge 193.
- Boundary values in byte 0 and byte 1: 8'hff → 12'h255; 8'h00 → 12'h000; 8'h09 → 12'h009; 8'h64 → 12'h100.
- in_valid held high throughout a scan with a different block → in_ready=0, nothing accepted until IDLE; second block accepted on the edge after DONE.
- LOOP=1, DWELL=1 → after byte 15 (0x5a → 12'h090), byte_index wraps to 0 and bcd_out returns to 12'h105 nine cycles later; done never asserts.
- clear asserted during CONVERT of byte 5 → next cycle state IDLE, bcd_out=0, digit_valid=0, byte_index=0, in_ready=1, no done pulse.
- reset driven low asynchronously mid-SHOW (between edges) → all outputs take reset values immediately, without waiting for a clock edge; normal scan resumes after release and a new accept.
